// File: rtl/main_mem_sequencer.sv
// Job sequencer for the HLS `main` accelerator: preloads its array over the slave
// port, pulses start, times the run, then streams the array back as 64-bit words.
module main_mem_sequencer #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 200000000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         job_go,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         job_done,
  output logic         timeout_err,
  output logic [31:0]  run_cycles,
  output logic         start_port,
  input  logic         done_port,
  output logic [1:0]   S_oe_ram,
  output logic [1:0]   S_we_ram,
  output logic [19:0]  S_addr_ram,
  output logic [127:0] S_Wdata_ram,
  output logic [13:0]  S_data_ram_size,
  input  logic [127:0] Sout_Rdata_ram,
  input  logic [1:0]   Sout_DataRdy
);

  localparam int unsigned   WORDS     = MEM_BYTES / 8;
  localparam int unsigned   WIDX      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(WORDS - 1);
  localparam logic [9:0]    BASE10    = 10'(BASE_ADDR);
  localparam logic [31:0]   TIMEOUT32 = 32'(TIMEOUT);
  localparam bit            TIMEOUT_AT_START = (TIMEOUT <= 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_START, S_RUN, S_READ_REQ, S_OUTPUT, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [WIDX-1:0] word_idx_q;
  logic [2:0]      byte_idx_q;
  logic [63:0]     wbuf_q;
  logic [63:0]     rbuf_q;
  logic [9:0]      addr_q;
  logic [31:0]     run_q;
  logic            terr_q;
  logic            last_word;
  logic            run_expired;
  logic            access;

  assign last_word   = (word_idx_q == LAST_WORD);
  assign run_expired = (run_q >= TIMEOUT32 - 32'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (job_go) state_d = S_COLLECT;
      S_COLLECT:  if (in_valid && byte_idx_q == 3'd7) state_d = S_WRITE;
      S_WRITE:    if (Sout_DataRdy[0]) state_d = last_word ? S_START : S_COLLECT;
      S_START: begin
        if (done_port)             state_d = S_READ_REQ;
        else if (TIMEOUT_AT_START) state_d = S_FINISH;
        else                       state_d = S_RUN;
      end
      S_RUN: begin
        if (done_port)        state_d = S_READ_REQ;
        else if (run_expired) state_d = S_FINISH;
      end
      S_READ_REQ: if (Sout_DataRdy[0]) state_d = S_OUTPUT;
      S_OUTPUT:   if (out_ready) state_d = last_word ? S_FINISH : S_READ_REQ;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The address register tracks word_idx so the slave address is never an adder output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
      addr_q     <= '0;
      run_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (job_go) begin
          word_idx_q <= '0;
          byte_idx_q <= '0;
          addr_q     <= BASE10;
          run_q      <= '0;
          terr_q     <= 1'b0;
        end
        S_COLLECT: if (in_valid) begin
          wbuf_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
          byte_idx_q <= byte_idx_q + 3'd1;
        end
        S_WRITE: if (Sout_DataRdy[0]) begin
          word_idx_q <= word_idx_q + WIDX'(1);
          addr_q     <= addr_q + 10'd8;
        end
        S_START: begin
          run_q <= 32'd1;
          if (done_port) begin
            word_idx_q <= '0;
            addr_q     <= BASE10;
          end else if (TIMEOUT_AT_START) begin
            terr_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (done_port) begin
            word_idx_q <= '0;
            addr_q     <= BASE10;
          end else begin
            run_q <= run_q + 32'd1;
            if (run_expired) terr_q <= 1'b1;
          end
        end
        S_READ_REQ: if (Sout_DataRdy[0]) rbuf_q <= Sout_Rdata_ram[63:0];
        S_OUTPUT: if (out_ready) begin
          word_idx_q <= word_idx_q + WIDX'(1);
          addr_q     <= addr_q + 10'd8;
        end
        default: ;
      endcase
    end
  end

  assign access          = (state_q == S_WRITE) || (state_q == S_READ_REQ);
  assign in_ready        = (state_q == S_COLLECT);
  assign out_valid       = (state_q == S_OUTPUT);
  assign out_last        = (state_q == S_OUTPUT) && last_word;
  assign out_data        = rbuf_q;
  assign busy            = (state_q != S_IDLE);
  assign job_done        = (state_q == S_FINISH);
  assign start_port      = (state_q == S_START);
  assign timeout_err     = terr_q;
  assign run_cycles      = run_q;
  assign S_we_ram        = {1'b0, state_q == S_WRITE};
  assign S_oe_ram        = {1'b0, state_q == S_READ_REQ};
  assign S_addr_ram      = {10'd0, addr_q};
  assign S_Wdata_ram     = {64'd0, wbuf_q};
  assign S_data_ram_size = {7'd0, access ? 7'd64 : 7'd0};

  logic unused_bits;
  assign unused_bits = ^{Sout_Rdata_ram[127:64], Sout_DataRdy[1]};

endmodule

// File: tb/tb_main_mem_sequencer.sv
// Directed bench for main_mem_sequencer: a small `main` slave model plus
// per-scenario tasks that preload, run, read back and check each job.
module tb_main_mem_sequencer;
  logic         clock = 1'b0;
  logic         reset;
  logic         job_go, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0]   in_data;
  logic [63:0]  out_data;
  logic         busy, job_done, timeout_err, start_port, done_port;
  logic [31:0]  run_cycles;
  logic [1:0]   S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [19:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [13:0]  S_data_ram_size;

  main_mem_sequencer #(.MEM_BYTES(256), .BASE_ADDR(0), .TIMEOUT(1000)) dut (
    .clock(clock), .reset(reset), .job_go(job_go),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .job_done(job_done), .timeout_err(timeout_err), .run_cycles(run_cycles),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [63:0]  mem [0:31];
  logic [9:0]   wr_addr [0:63];
  logic [63:0]  wr_data [0:63];
  int           wr_count, done_cnt, start_cnt, outv_cnt, bus_viol, stall_viol, rd_wait, got;
  bit           run_window;
  logic [7:0]   pat [0:255];
  logic [63:0]  got_words [0:31];
  bit           got_last [0:31];
  logic         terr_after_go;
  logic [31:0]  run_after_go;

  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = pat[8*w + b];
    return r;
  endfunction

  // Slave model: write completes in the request cycle, read after one wait cycle.
  initial begin
    Sout_DataRdy = '0;
    Sout_Rdata_ram = '0;
    rd_wait = 0;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        Sout_DataRdy = '0;
        rd_wait = 0;
      end else begin
        if (job_done) done_cnt++;
        if (start_port) start_cnt++;
        if (out_valid) outv_cnt++;
        if (S_we_ram[0] && S_oe_ram[0]) bus_viol++;
        if ((S_we_ram[0] || S_oe_ram[0]) && (start_port || run_window)) bus_viol++;
        if (S_we_ram[1] || S_oe_ram[1] || S_addr_ram[19:10] != 10'd0) bus_viol++;
        if ((S_we_ram[0] || S_oe_ram[0]) && S_data_ram_size != 14'd64) bus_viol++;
        if (S_we_ram[0]) begin
          if (!Sout_DataRdy[0]) begin
            if (S_Wdata_ram[127:64] != 64'd0) bus_viol++;
            mem[S_addr_ram[7:3]] = S_Wdata_ram[63:0];
            if (wr_count < 64) begin
              wr_addr[wr_count] = S_addr_ram[9:0];
              wr_data[wr_count] = S_Wdata_ram[63:0];
            end
            wr_count++;
            Sout_DataRdy = 2'b01;
          end
        end else if (S_oe_ram[0]) begin
          if (rd_wait == 0) begin
            rd_wait = 1;
            Sout_DataRdy = '0;
          end else begin
            rd_wait = 0;
            Sout_DataRdy = 2'b01;
            Sout_Rdata_ram = {64'hA5A5_5A5A_DEAD_BEEF, mem[S_addr_ram[7:3]]};
          end
        end else begin
          Sout_DataRdy = '0;
          rd_wait = 0;
        end
      end
    end
  end

  task automatic feed(input bit gap);
    int cyc = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data = pat[i];
      while (!in_ready && cyc < 4000) begin @(posedge clock); #1; cyc++; end
      @(posedge clock); #1; cyc++;
      if (gap) begin in_valid = 1'b0; @(posedge clock); #1; cyc++; end
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 4000) begin failures++; $display("FAIL feed_bound cycles=%0d limit=4000", cyc); end
  endtask

  task automatic consume(input int nwords, input bit stall);
    int cyc = 0;
    bit pend = 0;
    bit rdy;
    logic [63:0] prev = '0;
    while (got < nwords && cyc < 6000) begin
      @(posedge clock); #1; cyc++;
      if (pend && (!out_valid || out_data !== prev)) stall_viol++;
      rdy = stall ? (cyc % 4 == 0) : 1'b1;
      out_ready = rdy;
      pend = 0;
      if (out_valid) begin
        if (rdy) begin
          got_words[got] = out_data;
          got_last[got] = out_last;
          got++;
        end else begin
          pend = 1;
          prev = out_data;
        end
      end
    end
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (got < nwords) begin failures++; $display("FAIL consume_bound words=%0d required=%0d", got, nwords); end
  endtask

  task automatic drive_done(input int delay, input bit glitch);
    int cyc = 0;
    while (!start_port && cyc < 5000) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (!start_port) begin
      failures++;
      $display("FAIL start_bound start_port=%b required=1", start_port);
    end else begin
      run_window = 1;
      if (delay == 0) begin
        done_port = 1'b1;
        run_window = 0;
        @(posedge clock); #1;
        done_port = 1'b0;
      end else if (delay > 0) begin
        for (int k = 0; k < delay; k++) begin
          @(posedge clock); #1;
          job_go = glitch && (k == 9);
        end
        job_go = 1'b0;
        run_window = 0;
        done_port = 1'b1;
        @(posedge clock); #1;
        done_port = 1'b0;
      end else begin
        while (busy && cyc < 5000) begin @(posedge clock); #1; cyc++; end
        run_window = 0;
      end
    end
  endtask

  task automatic run_job(input int delay, input bit gap, input bit stall, input bit glitch,
                         input int nwords, input bit wait_idle);
    int cyc = 0;
    wr_count = 0; done_cnt = 0; start_cnt = 0; outv_cnt = 0;
    bus_viol = 0; stall_viol = 0; got = 0;
    job_go = 1'b1;
    @(posedge clock); #1;
    job_go = 1'b0;
    terr_after_go = timeout_err;
    run_after_go = run_cycles;
    fork
      feed(gap);
      drive_done(delay, glitch);
      begin if (nwords > 0) consume(nwords, stall); end
    join
    if (wait_idle) begin
      while (busy && cyc < 200) begin @(posedge clock); #1; cyc++; end
      checks++;
      if (busy) begin failures++; $display("FAIL idle_bound busy=%b required=0", busy); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, busy, job_done, timeout_err, run_cycles,
         start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b run=%0d addr=%h we=%b oe=%b size=%0d required all zero",
               busy, run_cycles, S_addr_ram, S_we_ram, S_oe_ram, S_data_ram_size);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_job1();
    int nl = 0;
    for (int i = 0; i < 256; i++) pat[i] = 8'(i);
    run_job(500, 1'b0, 1'b0, 1'b0, 32, 1'b1);
    checks++;
    if (wr_count != 32) begin failures++; $display("FAIL j1_writes got=%0d required=32", wr_count); end
    checks++;
    if (wr_addr[0] !== 10'd0 || wr_data[0] !== 64'h0706050403020100) begin
      failures++; $display("FAIL j1_first_write addr=%0d data=%h required 0 0706050403020100", wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[31] !== 10'd248 || wr_data[31] !== 64'hFFFEFDFCFBFAF9F8) begin
      failures++; $display("FAIL j1_last_write addr=%0d data=%h required 248 fffefdfcfbfaf9f8", wr_addr[31], wr_data[31]);
    end
    checks++;
    if (got_words[0] !== 64'h0706050403020100) begin
      failures++; $display("FAIL j1_out0 got=%h required=0706050403020100", got_words[0]);
    end
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (got_words[w] !== exp_word(w)) begin
        failures++; $display("FAIL j1_word%0d got=%h required=%h", w, got_words[w], exp_word(w));
      end
      nl += int'(got_last[w]);
    end
    checks++;
    if (nl != 1 || !got_last[31]) begin failures++; $display("FAIL j1_out_last count=%0d on31=%b required 1 1", nl, got_last[31]); end
    checks++;
    if (run_cycles !== 32'd500) begin failures++; $display("FAIL j1_run_cycles got=%0d required=500", run_cycles); end
    checks++;
    if (done_cnt != 1 || start_cnt != 1) begin failures++; $display("FAIL j1_pulses done=%0d start=%0d required 1 1", done_cnt, start_cnt); end
    checks++;
    if (bus_viol != 0 || timeout_err !== 1'b0) begin failures++; $display("FAIL j1_bus viol=%0d terr=%b required 0 0", bus_viol, timeout_err); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 256; i++) pat[i] = 8'(i * 7 + 3);
    run_job(300, 1'b1, 1'b1, 1'b0, 32, 1'b1);
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (got_words[w] !== exp_word(w)) begin
        failures++; $display("FAIL bp_word%0d got=%h required=%h", w, got_words[w], exp_word(w));
      end
    end
    checks++;
    if (stall_viol != 0) begin failures++; $display("FAIL bp_stall_stable violations=%0d required=0", stall_viol); end
    checks++;
    if (run_cycles !== 32'd300 || done_cnt != 1) begin
      failures++; $display("FAIL bp_run run=%0d done=%0d required 300 1", run_cycles, done_cnt);
    end
    checks++;
    if (bus_viol != 0) begin failures++; $display("FAIL bp_bus viol=%0d required=0", bus_viol); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 256; i++) pat[i] = 8'(255 - i);
    run_job(-1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b required=1", timeout_err); end
    checks++;
    if (run_cycles !== 32'd1000) begin failures++; $display("FAIL to_run_cycles got=%0d required=1000", run_cycles); end
    checks++;
    if (outv_cnt != 0 || done_cnt != 1) begin
      failures++; $display("FAIL to_readback out_valid_cycles=%0d done=%0d required 0 1", outv_cnt, done_cnt);
    end
    checks++;
    if (wr_count != 32) begin failures++; $display("FAIL to_writes got=%0d required=32", wr_count); end
  endtask

  task automatic test_done_at_start();
    for (int i = 0; i < 256; i++) pat[i] = 8'(i) ^ 8'hC3;
    run_job(0, 1'b0, 1'b0, 1'b0, 32, 1'b1);
    checks++;
    if (terr_after_go !== 1'b0 || run_after_go !== 32'd0) begin
      failures++; $display("FAIL go_clears terr=%b run=%0d required 0 0", terr_after_go, run_after_go);
    end
    checks++;
    if (run_cycles !== 32'd1 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL das_run run=%0d terr=%b required 1 0", run_cycles, timeout_err);
    end
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (got_words[w] !== exp_word(w)) begin
        failures++; $display("FAIL das_word%0d got=%h required=%h", w, got_words[w], exp_word(w));
      end
    end
    checks++;
    if (done_cnt != 1 || bus_viol != 0) begin failures++; $display("FAIL das_done done=%0d viol=%0d required 1 0", done_cnt, bus_viol); end
  endtask

  task automatic test_go_during_run();
    for (int i = 0; i < 256; i++) pat[i] = 8'(i) ^ 8'h3C;
    run_job(200, 1'b0, 1'b0, 1'b1, 32, 1'b1);
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (done_cnt != 1 || start_cnt != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL gdr_single_job done=%0d start=%0d busy=%b required 1 1 0", done_cnt, start_cnt, busy);
    end
    checks++;
    if (run_cycles !== 32'd200) begin failures++; $display("FAIL gdr_run_cycles got=%0d required=200", run_cycles); end
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (got_words[w] !== exp_word(w)) begin
        failures++; $display("FAIL gdr_word%0d got=%h required=%h", w, got_words[w], exp_word(w));
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int cyc = 0;
    for (int i = 0; i < 256; i++) pat[i] = 8'(i) ^ 8'h5A;
    run_job(20, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    checks++;
    if (got_words[9] !== exp_word(9)) begin
      failures++; $display("FAIL rm_word9 got=%h required=%h", got_words[9], exp_word(9));
    end
    while (!out_valid && cyc < 50) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL rm_word10_bound out_valid=%b required=1", out_valid); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, busy, job_done, timeout_err, run_cycles,
         start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== '0) begin
      failures++;
      $display("FAIL rm_reset_outputs busy=%b out_valid=%b data=%h run=%0d addr=%h required all zero",
               busy, out_valid, out_data, run_cycles, S_addr_ram);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_job_after_reset();
    for (int i = 0; i < 256; i++) pat[i] = 8'(i * 3);
    run_job(50, 1'b0, 1'b0, 1'b0, 32, 1'b1);
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (got_words[w] !== exp_word(w)) begin
        failures++; $display("FAIL ar_word%0d got=%h required=%h", w, got_words[w], exp_word(w));
      end
    end
    checks++;
    if (run_cycles !== 32'd50 || done_cnt != 1 || wr_count != 32) begin
      failures++; $display("FAIL ar_job run=%0d done=%0d writes=%0d required 50 1 32", run_cycles, done_cnt, wr_count);
    end
  endtask

  initial begin
    reset = 1'b0; job_go = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; done_port = 1'b0; run_window = 0;
    test_reset();
    test_job1();
    test_backpressure();
    test_timeout();
    test_done_at_start();
    test_go_during_run();
    test_reset_mid_job();
    test_job_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
